// File: rtl/m68k_bus_req_if.sv
// Signal bundle between the 68040 bus front end and the Wishbone request bridge.
// The master view belongs to m68k_bus_req; the slave view belongs to the CPU pads and bridge.
interface m68k_bus_req_if;
    logic        bus_ts;
    logic        bus_rw;
    logic [1:0]  bus_siz;
    logic [31:0] bus_addr;
    logic [31:0] bus_data_i;
    logic [31:0] bus_data_o;
    logic        bus_data_oe;
    logic        bus_ta;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_wrap;
    logic [2:0]  req_len;
    logic [31:0] req_addr;
    logic [3:0]  req_mask;

    logic        write_valid;
    logic [31:0] write_data;
    logic        read_valid;
    logic [31:0] read_data;
    logic        read_ack;

    modport master (
        input  bus_ts, bus_rw, bus_siz, bus_addr, bus_data_i,
        output bus_data_o, bus_data_oe, bus_ta,
        output req_valid, req_we, req_wrap, req_len, req_addr, req_mask,
        input  req_ready,
        output write_valid, write_data, read_ack,
        input  read_valid, read_data
    );

    modport slave (
        output bus_ts, bus_rw, bus_siz, bus_addr, bus_data_i,
        input  bus_data_o, bus_data_oe, bus_ta,
        input  req_valid, req_we, req_wrap, req_len, req_addr, req_mask,
        output req_ready,
        input  write_valid, write_data, read_ack,
        output read_valid, read_data
    );
endinterface

// File: rtl/m68k_bus_req.sv
// Converts one 68040 bus cycle into a single bridge request, then moves the data
// beats between the CPU bus and the bridge FIFOs with one transfer acknowledge per beat.
module m68k_bus_req #(
    parameter int unsigned LINE_BEATS = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    m68k_bus_req_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } state_t;

    state_t      state_q;
    logic [2:0]  beat_q;
    logic        req_valid_q;
    logic        req_we_q;
    logic        req_wrap_q;
    logic [2:0]  req_len_q;
    logic [31:0] req_addr_q;
    logic [3:0]  req_mask_q;

    logic        beat_take;
    logic        beat_last;

    // Big-endian lanes: mask bit 3 is byte 0 on bits [31:24]; word transfers ignore A0.
    function automatic logic [3:0] lane_mask(input logic [1:0] siz, input logic [1:0] a);
        case (siz)
            2'b01:   lane_mask = 4'b1000 >> a;
            2'b10:   lane_mask = a[1] ? 4'b0011 : 4'b1100;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    always_comb begin
        beat_take = (state_q == WDATA) || ((state_q == RDATA) && bus.read_valid);
        beat_last = beat_take && (beat_q == (req_len_q - 3'd1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            beat_q      <= 3'd0;
            req_valid_q <= 1'b0;
            req_we_q    <= 1'b0;
            req_wrap_q  <= 1'b0;
            req_len_q   <= 3'd0;
            req_addr_q  <= 32'd0;
            req_mask_q  <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.bus_ts) begin
                        req_valid_q <= 1'b1;
                        req_we_q    <= !bus.bus_rw;
                        req_mask_q  <= lane_mask(bus.bus_siz, bus.bus_addr[1:0]);
                        beat_q      <= 3'd0;
                        state_q     <= REQ;
                        // Line bursts keep A[3:2] so the bridge wraps critical-word-first.
                        if (bus.bus_siz == 2'b11) begin
                            req_len_q  <= 3'(LINE_BEATS);
                            req_wrap_q <= 1'b1;
                            req_addr_q <= {bus.bus_addr[31:2], 2'b00};
                        end else begin
                            req_len_q  <= 3'd1;
                            req_wrap_q <= 1'b0;
                            req_addr_q <= bus.bus_addr;
                        end
                    end
                end
                REQ: begin
                    if (bus.req_ready) begin
                        req_valid_q <= 1'b0;
                        state_q     <= req_we_q ? WDATA : RDATA;
                    end
                end
                WDATA, RDATA: begin
                    if (beat_take) begin
                        beat_q <= beat_q + 3'd1;
                        if (beat_last) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Writes are posted: each beat is acknowledged as it is pushed into the write FIFO.
    assign bus.bus_ta      = beat_take;
    assign bus.bus_data_oe = (state_q == RDATA);
    assign bus.bus_data_o  = ((state_q == RDATA) && bus.read_valid) ? bus.read_data : 32'd0;
    assign bus.read_ack    = (state_q == RDATA) && bus.read_valid;
    assign bus.write_valid = (state_q == WDATA);
    assign bus.write_data  = (state_q == WDATA) ? bus.bus_data_i : 32'd0;

    assign bus.req_valid   = req_valid_q;
    assign bus.req_we      = req_we_q;
    assign bus.req_wrap    = req_wrap_q;
    assign bus.req_len     = req_len_q;
    assign bus.req_addr    = req_addr_q;
    assign bus.req_mask    = req_mask_q;

endmodule

// File: tb/tb_m68k_bus_req.sv
// Directed bench for m68k_bus_req: inputs change on the falling edge, outputs are
// sampled 1 ns later, expected values are written out by hand per scenario.
module tb_m68k_bus_req;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    m68k_bus_req_if bif ();

    m68k_bus_req #(.LINE_BEATS(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bif.bus_ts     = 1'b0;
        bif.bus_rw     = 1'b1;
        bif.bus_siz    = 2'b00;
        bif.bus_addr   = 32'd0;
        bif.bus_data_i = 32'd0;
        bif.req_ready  = 1'b1;
        bif.read_valid = 1'b0;
        bif.read_data  = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        #1;
        checks++;
        if ({bif.req_valid, bif.bus_ta, bif.bus_data_oe, bif.write_valid, bif.read_ack} !== 5'b0) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=00000",
                     {bif.req_valid, bif.bus_ta, bif.bus_data_oe, bif.write_valid, bif.read_ack});
        end
        checks++;
        if ({bif.req_we, bif.req_wrap, bif.req_len, bif.req_mask, bif.req_addr, bif.bus_data_o} !== 73'd0) begin
            failures++;
            $display("FAIL reset_attrs got=%h exp=0",
                     {bif.req_we, bif.req_wrap, bif.req_len, bif.req_mask, bif.req_addr, bif.bus_data_o});
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_byte_write();
        tick();
        bif.bus_ts = 1'b1; bif.bus_rw = 1'b0; bif.bus_siz = 2'b01;
        bif.bus_addr = 32'h0000_1003; bif.bus_data_i = 32'h0000_00AB; bif.req_ready = 1'b0;
        tick();
        bif.bus_ts = 1'b0;
        #1;
        checks++;
        if ({bif.req_valid, bif.req_we, bif.req_wrap, bif.req_len, bif.req_mask, bif.req_addr, bif.bus_ta}
            !== {1'b1, 1'b1, 1'b0, 3'd1, 4'b0001, 32'h0000_1003, 1'b0}) begin
            failures++;
            $display("FAIL byte_write_req got=%h exp=%h",
                     {bif.req_valid, bif.req_we, bif.req_wrap, bif.req_len, bif.req_mask, bif.req_addr, bif.bus_ta},
                     {1'b1, 1'b1, 1'b0, 3'd1, 4'b0001, 32'h0000_1003, 1'b0});
        end
        bif.req_ready = 1'b1;
        tick();
        #1;
        checks++;
        if ({bif.bus_ta, bif.write_valid, bif.write_data, bif.req_valid} !== {1'b1, 1'b1, 32'h0000_00AB, 1'b0}) begin
            failures++;
            $display("FAIL byte_write_beat got=%h exp=%h",
                     {bif.bus_ta, bif.write_valid, bif.write_data, bif.req_valid},
                     {1'b1, 1'b1, 32'h0000_00AB, 1'b0});
        end
        tick();
        #1;
        checks++;
        if ({bif.bus_ta, bif.write_valid, bif.req_valid} !== 3'b000) begin
            failures++;
            $display("FAIL byte_write_idle got=%b exp=000", {bif.bus_ta, bif.write_valid, bif.req_valid});
        end
    endtask

    task automatic test_word_write();
        logic [31:0] addrs [2];
        logic [3:0]  masks [2];
        addrs[0] = 32'h0000_0012; masks[0] = 4'b0011;
        addrs[1] = 32'h0000_0010; masks[1] = 4'b1100;
        for (int i = 0; i < 2; i++) begin
            tick();
            bif.bus_ts = 1'b1; bif.bus_rw = 1'b0; bif.bus_siz = 2'b10;
            bif.bus_addr = addrs[i]; bif.bus_data_i = 32'h1234_5678 + i;
            tick();
            bif.bus_ts = 1'b0;
            #1;
            checks++;
            if ({bif.req_valid, bif.req_len, bif.req_mask, bif.req_addr} !== {1'b1, 3'd1, masks[i], addrs[i]}) begin
                failures++;
                $display("FAIL word_write_req%0d got=%h exp=%h", i,
                         {bif.req_valid, bif.req_len, bif.req_mask, bif.req_addr},
                         {1'b1, 3'd1, masks[i], addrs[i]});
            end
            tick();
            #1;
            checks++;
            if ({bif.bus_ta, bif.write_valid, bif.write_data} !== {1'b1, 1'b1, 32'h1234_5678 + i}) begin
                failures++;
                $display("FAIL word_write_beat%0d got=%h exp=%h", i,
                         {bif.bus_ta, bif.write_valid, bif.write_data}, {1'b1, 1'b1, 32'h1234_5678 + i});
            end
        end
        tick();
        #1;
        checks++;
        if (bif.bus_ta !== 1'b0) begin
            failures++;
            $display("FAIL word_write_idle bus_ta got=%b exp=0", bif.bus_ta);
        end
    endtask

    task automatic test_line_read();
        logic        rv_pat [6];
        logic [31:0] d [4];
        int          k;
        int          ta_cnt;
        rv_pat[0] = 1'b1; rv_pat[1] = 1'b0; rv_pat[2] = 1'b1;
        rv_pat[3] = 1'b1; rv_pat[4] = 1'b0; rv_pat[5] = 1'b1;
        d[0] = 32'hD000_0000; d[1] = 32'hD111_1111; d[2] = 32'hD222_2222; d[3] = 32'hD333_3333;
        k = 0;
        ta_cnt = 0;
        tick();
        bif.bus_ts = 1'b1; bif.bus_rw = 1'b1; bif.bus_siz = 2'b11; bif.bus_addr = 32'h0000_2008;
        tick();
        bif.bus_ts = 1'b0;
        #1;
        checks++;
        if ({bif.req_valid, bif.req_we, bif.req_wrap, bif.req_len, bif.req_mask, bif.req_addr, bif.bus_ta}
            !== {1'b1, 1'b0, 1'b1, 3'd4, 4'b1111, 32'h0000_2008, 1'b0}) begin
            failures++;
            $display("FAIL line_read_req got=%h exp=%h",
                     {bif.req_valid, bif.req_we, bif.req_wrap, bif.req_len, bif.req_mask, bif.req_addr, bif.bus_ta},
                     {1'b1, 1'b0, 1'b1, 3'd4, 4'b1111, 32'h0000_2008, 1'b0});
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            bif.read_valid = rv_pat[i];
            bif.read_data  = rv_pat[i] ? d[k] : 32'hDEAD_0000;
            #1;
            checks++;
            if ({bif.bus_data_oe, bif.bus_ta, bif.read_ack} !== {1'b1, rv_pat[i], rv_pat[i]}) begin
                failures++;
                $display("FAIL line_read_strobe%0d got=%b exp=%b", i,
                         {bif.bus_data_oe, bif.bus_ta, bif.read_ack}, {1'b1, rv_pat[i], rv_pat[i]});
            end
            ta_cnt += int'(bif.bus_ta);
            if (rv_pat[i]) begin
                checks++;
                if (bif.bus_data_o !== d[k]) begin
                    failures++;
                    $display("FAIL line_read_data%0d got=%h exp=%h", k, bif.bus_data_o, d[k]);
                end
                k++;
            end
        end
        tick();
        bif.read_valid = 1'b0;
        #1;
        checks++;
        if ({bif.bus_data_oe, bif.bus_ta, ta_cnt} !== {1'b0, 1'b0, 32'd4}) begin
            failures++;
            $display("FAIL line_read_end oe=%b ta=%b ta_count=%0d exp oe=0 ta=0 ta_count=4",
                     bif.bus_data_oe, bif.bus_ta, ta_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [4];
        w[0] = 32'hA0A0_A0A0; w[1] = 32'hB1B1_B1B1; w[2] = 32'hC2C2_C2C2; w[3] = 32'hE3E3_E3E3;
        tick();
        bif.bus_ts = 1'b1; bif.bus_rw = 1'b0; bif.bus_siz = 2'b11; bif.bus_addr = 32'h0000_300C;
        tick();
        bif.bus_ts = 1'b0;
        #1;
        checks++;
        if ({bif.req_valid, bif.req_we, bif.req_wrap, bif.req_len, bif.req_addr, bif.bus_ta}
            !== {1'b1, 1'b1, 1'b1, 3'd4, 32'h0000_300C, 1'b0}) begin
            failures++;
            $display("FAIL line_write_req got=%h exp=%h",
                     {bif.req_valid, bif.req_we, bif.req_wrap, bif.req_len, bif.req_addr, bif.bus_ta},
                     {1'b1, 1'b1, 1'b1, 3'd4, 32'h0000_300C, 1'b0});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            bif.bus_data_i = w[i];
            #1;
            checks++;
            if ({bif.bus_ta, bif.write_valid, bif.write_data} !== {1'b1, 1'b1, w[i]}) begin
                failures++;
                $display("FAIL line_write_beat%0d got=%h exp=%h", i,
                         {bif.bus_ta, bif.write_valid, bif.write_data}, {1'b1, 1'b1, w[i]});
            end
        end
        tick();
        bif.bus_ts = 1'b1; bif.bus_rw = 1'b1; bif.bus_siz = 2'b00; bif.bus_addr = 32'h0000_4004;
        bif.req_ready = 1'b0;
        #1;
        checks++;
        if ({bif.bus_ta, bif.write_valid} !== 2'b00) begin
            failures++;
            $display("FAIL line_write_done got=%b exp=00", {bif.bus_ta, bif.write_valid});
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            bif.bus_ts = 1'b0;
            #1;
            checks++;
            if ({bif.req_valid, bif.req_we, bif.req_wrap, bif.req_len, bif.req_mask, bif.req_addr, bif.bus_ta}
                !== {1'b1, 1'b0, 1'b0, 3'd1, 4'b1111, 32'h0000_4004, 1'b0}) begin
                failures++;
                $display("FAIL stall_req%0d got=%h exp=%h", i,
                         {bif.req_valid, bif.req_we, bif.req_wrap, bif.req_len, bif.req_mask, bif.req_addr, bif.bus_ta},
                         {1'b1, 1'b0, 1'b0, 3'd1, 4'b1111, 32'h0000_4004, 1'b0});
            end
        end
        tick();
        bif.req_ready = 1'b1;
        tick();
        bif.read_valid = 1'b1; bif.read_data = 32'hCAFE_BABE;
        #1;
        checks++;
        if ({bif.bus_ta, bif.read_ack, bif.bus_data_oe, bif.bus_data_o, bif.req_valid}
            !== {1'b1, 1'b1, 1'b1, 32'hCAFE_BABE, 1'b0}) begin
            failures++;
            $display("FAIL long_read_beat got=%h exp=%h",
                     {bif.bus_ta, bif.read_ack, bif.bus_data_oe, bif.bus_data_o, bif.req_valid},
                     {1'b1, 1'b1, 1'b1, 32'hCAFE_BABE, 1'b0});
        end
        tick();
        bif.read_valid = 1'b0;
        #1;
        checks++;
        if ({bif.bus_ta, bif.bus_data_oe} !== 2'b00) begin
            failures++;
            $display("FAIL long_read_idle got=%b exp=00", {bif.bus_ta, bif.bus_data_oe});
        end
    endtask

    task automatic test_reset_mid_burst();
        tick();
        bif.bus_ts = 1'b1; bif.bus_rw = 1'b1; bif.bus_siz = 2'b11; bif.bus_addr = 32'h0000_5000;
        tick();
        bif.bus_ts = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            bif.read_valid = 1'b1; bif.read_data = 32'h5555_0000 + i;
            #1;
            checks++;
            if ({bif.bus_ta, bif.bus_data_o} !== {1'b1, 32'h5555_0000 + i}) begin
                failures++;
                $display("FAIL abort_beat%0d got=%h exp=%h", i, {bif.bus_ta, bif.bus_data_o},
                         {1'b1, 32'h5555_0000 + i});
            end
        end
        tick();
        bif.read_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({bif.bus_ta, bif.bus_data_oe, bif.req_valid, bif.read_ack} !== 4'b0000) begin
            failures++;
            $display("FAIL abort_idle got=%b exp=0000",
                     {bif.bus_ta, bif.bus_data_oe, bif.req_valid, bif.read_ack});
        end
        tick();
        bif.bus_ts = 1'b1; bif.bus_rw = 1'b1; bif.bus_siz = 2'b01; bif.bus_addr = 32'h0000_6002;
        tick();
        bif.bus_ts = 1'b0;
        #1;
        checks++;
        if ({bif.req_valid, bif.req_we, bif.req_wrap, bif.req_len, bif.req_mask, bif.req_addr}
            !== {1'b1, 1'b0, 1'b0, 3'd1, 4'b0010, 32'h0000_6002}) begin
            failures++;
            $display("FAIL byte_read_req got=%h exp=%h",
                     {bif.req_valid, bif.req_we, bif.req_wrap, bif.req_len, bif.req_mask, bif.req_addr},
                     {1'b1, 1'b0, 1'b0, 3'd1, 4'b0010, 32'h0000_6002});
        end
        tick();
        bif.read_valid = 1'b1; bif.read_data = 32'h1122_3344;
        #1;
        checks++;
        if ({bif.bus_ta, bif.read_ack, bif.bus_data_o} !== {1'b1, 1'b1, 32'h1122_3344}) begin
            failures++;
            $display("FAIL byte_read_beat got=%h exp=%h", {bif.bus_ta, bif.read_ack, bif.bus_data_o},
                     {1'b1, 1'b1, 32'h1122_3344});
        end
        tick();
        bif.read_valid = 1'b0;
        #1;
        checks++;
        if ({bif.bus_ta, bif.bus_data_oe} !== 2'b00) begin
            failures++;
            $display("FAIL byte_read_idle got=%b exp=00", {bif.bus_ta, bif.bus_data_oe});
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_byte_write();
        test_word_write();
        test_line_read();
        test_back_to_back();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/m68k_bus_req.md
# m68k_bus_req

Front end of the memory path: it turns one 68040 bus cycle into one request on the req/write/read interface of the downstream Wishbone request bridge. Each cycle is a single byte, word or longword transfer, or a 4-beat line burst. The block latches the transfer attributes on transfer start and presents a single request. It then moves the data beats between the CPU data bus and the bridge's write and read FIFOs, generating a transfer acknowledge per beat. Writes are posted: the CPU is acknowledged as soon as each beat is pushed into the write FIFO.

## Interface
- LINE_BEATS, 4: beats per line transfer (SIZ=11). Must be ≤ the bridge FIFO depth and ≤ 7.
- clk_i  in  1  single system clock (the CPU bus clock); everything is on its rising edge.
- rst_i  in  1  reset, synchronous and active-high.
- bus_ts  in  1  transfer start, active-high, already synchronised and inverted at the pads.
- bus_rw  in  1  1 = read, 0 = write; sampled with bus_ts.
- bus_siz  in  2  00 long, 01 byte, 10 word, 11 line; sampled with bus_ts.
- bus_addr  in  32  byte address; sampled with bus_ts.
- bus_data_i  in  32  CPU write data; big-endian, with byte 0 on bits [31:24].
- bus_data_o  out  32  read data to the CPU.
- bus_data_oe  out  1  read data drive enable.
- bus_ta  out  1  transfer acknowledge, one cycle per beat.
- req_valid  out  1  request to the bridge.
- req_ready  in  1  bridge ready.
- req_we, req_wrap  out  1 each  request attributes.
- req_len  out  3  number of beats.
- req_addr  out  32  request byte address.
- req_mask  out  4  byte enables, with bit 3 selecting bits [31:24].
- write_valid  out  1  push enable for the write FIFO.
- write_data  out  32  write FIFO data.
- read_valid  in  1  read FIFO is not empty.
- read_data  in  32  head of the read FIFO.
- read_ack  out  1  pop the read FIFO.

## Operation
- States: IDLE, REQ, WDATA, RDATA. The state register is the only sequential control.
- IDLE
  - bus_ts=1: latch rw, siz and addr, clear the beat counter, go to REQ.
  - bus_ts in any other state is ignored; the 68040 does not overlap cycles.
- Request attributes, derived from the latched fields:
  - req_we = !rw.
  - Line transfers: req_len = LINE_BEATS, req_wrap=1, req_mask=4'b1111, req_addr = {addr[31:2],2'b00}. This keeps A[3:2], so the bridge wraps within the line (critical word first).
  - Non-line transfers: req_len=1, req_wrap=0, req_addr=addr.
  - Masks:
    - byte: 4'b1000>>addr[1:0];
    - word: addr[1]=0 → 4'b1100, addr[1]=1 → 4'b0011, with addr[0] ignored;
    - long: 4'b1111.
- REQ
  - req_valid=1, held with stable attributes until req_valid&req_ready both sample high.
  - On that cycle go to WDATA if it is a write, otherwise RDATA.
  - A previous posted write still draining keeps req_ready low, so REQ simply waits; bus order is preserved.
- WDATA
  - Every cycle: bus_ta=1, write_valid=1, write_data=bus_data_i, beat counter +1.
  - After the req_len-th beat go to IDLE.
  - No back-pressure check is needed: at most LINE_BEATS words are pushed into an empty FIFO.
- RDATA
  - bus_data_oe=1.
  - When read_valid=1: bus_ta=1, read_ack=1 and bus_data_o=read_data in the same cycle, then beat counter +1.
  - When read_valid=0: bus_ta=0 (wait state).
  - After the last beat go to IDLE.
- Beat counter: 3 bits. Terminal when it equals req_len-1 and the beat is taken.

## Timing
- Reset values: state IDLE, with req_valid, bus_ta, bus_data_oe, write_valid and read_ack all 0. req_* attributes and bus_data_o are 0.
- bus_ta, write_valid, read_ack and bus_data_o are combinational from the state, the counter and read_valid. req_* are registered.
- Timeline from bus_ts sampled at edge N:
  - req_valid is high from cycle N+1.
  - Writes: the earliest first bus_ta is in the cycle after the handshake. A line write then takes 4 consecutive bus_ta cycles.
  - Reads: the first bus_ta is in the first RDATA cycle with read_valid=1.
- Exactly one bus_ta per beat; bus_ta is never asserted in IDLE or REQ.
- Reset in any state returns to IDLE the next cycle with all strobes low, and a partial burst is abandoned. The bridge shares rst_i, so its FIFOs are flushed together with this block.

## Test plan
- Byte write: bus_ts, rw=0, siz=01, addr=0x0000_1003, data 0x0000_00AB → one handshake with req_we=1, len=1, wrap=0, mask=0001, addr=0x1003; one write_valid with 0x0000_00AB; one bus_ta; back to IDLE.
- Word write at 0x0000_0012 → mask=0011. Word write at 0x0000_0010 → mask=1100.
- Line read at 0x0000_2008, read_valid toggling 1,0,1,1,0,1 with data D0..D3 → req_len=4, wrap=1, addr=0x2008; 4 bus_ta pulses aligned to the read_valid=1 cycles with bus_data_o = D0..D3; 4 read_ack pulses.
- Line write followed immediately by a long read, with req_ready held low for 10 cycles after the write → the read's req_valid stays high and its attributes stay stable until req_ready rises; no bus_ta is issued during the wait.
- Reset asserted after the 2nd beat of a line read → next cycle state is IDLE with bus_ta, bus_data_oe and req_valid at 0. A following byte read completes normally.
- Line write → exactly 4 consecutive bus_ta cycles, and write_data equals bus_data_i in each of those cycles.
